// File: rtl/wrr_pkt_sched_if.sv
// Handshake bundle between the queue array, the downstream port and the WRR scheduler.
// The master side drives the queue status and weights. The slave side is the scheduler.
interface wrr_pkt_sched_if #(
  parameter int NQ = 3,
  parameter int WW = 4
);
  logic [NQ-1:0]    q_rdy;
  logic             pkt_last;
  logic             dq_ready;
  logic [NQ*WW-1:0] weight;
  logic [NQ-1:0]    sel;
  logic             fire;
  logic             turn_done;
  logic             busy;

  modport master (
    output q_rdy, pkt_last, dq_ready, weight,
    input  sel, fire, turn_done, busy
  );

  modport slave (
    input  q_rdy, pkt_last, dq_ready, weight,
    output sel, fire, turn_done, busy
  );
endinterface

// File: rtl/wrr_pkt_sched.sv
// Weighted round-robin packet scheduler: grants one queue per turn, for up to weight[q] whole packets,
// and drives a registered one-hot select for the downstream datapath mux.
module wrr_pkt_sched #(
  parameter int NQ = 3,
  parameter int WW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  wrr_pkt_sched_if.slave   bus
);

  localparam int PW = (NQ > 1) ? $clog2(NQ) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_nx;
  logic [NQ-1:0] sel_q, sel_nx;
  logic [PW-1:0] ptr, ptr_nx;
  logic [PW-1:0] cur, cur_nx;
  logic [WW-1:0] credit, credit_nx;
  logic          at_bnd, at_bnd_nx;
  logic          turn_done_q;
  logic          release_c;
  logic          fire_c;
  logic [PW:0]   pick_r;
  logic [PW-1:0] win;
  logic [WW-1:0] win_w;

  // First ready queue at or after p, wrapping modulo NQ; MSB flags a hit.
  function automatic logic [PW:0] pick(input logic [NQ-1:0] req, input logic [PW-1:0] p);
    logic [PW:0] r;
    int          idx;
    r = '0;
    for (int i = NQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NQ;
      if (req[idx]) r = {1'b1, PW'(idx)};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return PW'((int'(i) + 1) % NQ);
  endfunction

  assign fire_c = (|(sel_q & bus.q_rdy)) && bus.dq_ready;
  assign pick_r = pick(bus.q_rdy, ptr);
  assign win    = pick_r[PW-1:0];
  assign win_w  = bus.weight[win*WW +: WW];

  always_comb begin
    state_nx  = state;
    sel_nx    = sel_q;
    ptr_nx    = ptr;
    cur_nx    = cur;
    credit_nx = credit;
    at_bnd_nx = at_bnd;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        if (pick_r[PW]) begin
          state_nx  = XFER;
          sel_nx    = NQ'(1) << win;
          cur_nx    = win;
          credit_nx = (win_w == '0) ? WW'(1) : win_w;
          at_bnd_nx = 1'b1;
        end
      end
      XFER: begin
        if (fire_c) begin
          if (bus.pkt_last) begin
            at_bnd_nx = 1'b1;
            if (credit > WW'(1)) credit_nx = credit - 1'b1;
            else                 release_c = 1'b1;
          end else begin
            at_bnd_nx = 1'b0;
          end
        end else if (at_bnd && !bus.q_rdy[cur]) begin
          // Queue ran dry between packets: give the port away early.
          release_c = 1'b1;
        end
        if (release_c) begin
          sel_nx   = '0;
          state_nx = IDLE;
          ptr_nx   = next_idx(cur);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel_q       <= '0;
      ptr         <= '0;
      cur         <= '0;
      credit      <= '0;
      at_bnd      <= 1'b1;
      turn_done_q <= 1'b0;
    end else begin
      state       <= state_nx;
      sel_q       <= sel_nx;
      ptr         <= ptr_nx;
      cur         <= cur_nx;
      credit      <= credit_nx;
      at_bnd      <= at_bnd_nx;
      turn_done_q <= release_c;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.fire      = fire_c;
  assign bus.turn_done = turn_done_q;
  assign bus.busy      = (state == XFER);

endmodule
